// File: rtl/fpu_pkg.sv
// Shared FPU issue definitions: opcode constants, multi-cycle classification,
// canonical NaN, exception flag positions and the issue FSM encoding.
package fpu_pkg;

    localparam logic [4:0] OP_FADD  = 5'b00000;
    localparam logic [4:0] OP_FSUB  = 5'b00001;
    localparam logic [4:0] OP_FDIV  = 5'b00010;
    localparam logic [4:0] OP_FSQRT = 5'b00011;
    localparam logic [4:0] OP_FMUL  = 5'b00100;
    localparam logic [4:0] OP_FREM  = 5'b01011;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MULTI = 2'd1,
        ST_DRAIN = 2'd2
    } fpu_state_e;

    function automatic logic is_multicycle(input logic [4:0] op);
        return (op == OP_FDIV) || (op == OP_FSQRT) || (op == OP_FREM);
    endfunction

endpackage

// File: rtl/fpu_timeout_cnt.sv
// Watchdog counter for an outstanding multi-cycle FPU op; expire marks the
// last cycle the FPU is allowed before completion is forced.
module fpu_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expire = (cnt == LAST);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Initiator side of the FPU start/op handshake: issues decode instructions,
// holds start for multi-cycle ops, and registers results for writeback.
//   state | meaning
//   IDLE  | operands pass through from decode; single-cycle ops issue here
//   MULTI | start held, decode stalled, waiting for done/flush/timeout
//   DRAIN | one-cycle start-low gap; writeback strobe for the finished op
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_op,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_a,
    input  logic [31:0] id_b,
    input  logic        ex_flush,
    output logic        fpu_start,
    output logic [4:0]  fpu_op,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    input  logic        fpu_done,
    input  logic [31:0] fpu_result,
    input  logic [4:0]  fpu_flags,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_result,
    output logic [4:0]  wb_flags,
    output logic        timeout_err
);

    fpu_state_e  state_q, state_d;
    logic [4:0]  op_q, rd_q;
    logic [31:0] a_q, b_q;
    logic        take_single, take_multi, take_done, take_timeout;
    logic        expire;

    fpu_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clr    (take_multi),
        .en     (state_q == ST_MULTI),
        .expire (expire)
    );

    always_comb begin
        state_d      = state_q;
        fpu_start    = 1'b0;
        stall        = 1'b0;
        fpu_op       = op_q;
        fpu_a        = a_q;
        fpu_b        = b_q;
        take_single  = 1'b0;
        take_multi   = 1'b0;
        take_done    = 1'b0;
        take_timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                fpu_op = id_op;
                fpu_a  = id_a;
                fpu_b  = id_b;
                if (id_valid && !ex_flush) begin
                    if (is_multicycle(id_op)) begin
                        stall      = 1'b1;
                        take_multi = 1'b1;
                        state_d    = ST_MULTI;
                    end else begin
                        fpu_start   = 1'b1;
                        take_single = 1'b1;
                    end
                end
            end
            ST_MULTI: begin
                fpu_start = 1'b1;
                stall     = 1'b1;
                // flush outranks a coincident done: the result is discarded
                if (ex_flush) begin
                    state_d = ST_DRAIN;
                end else if (fpu_done) begin
                    take_done = 1'b1;
                    state_d   = ST_DRAIN;
                end else if (expire) begin
                    take_timeout = 1'b1;
                    state_d      = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // keep the FPU and decode interfaces quiet while reset is asserted
        if (!reset) begin
            fpu_start = 1'b0;
            stall     = 1'b0;
            fpu_op    = '0;
            fpu_a     = '0;
            fpu_b     = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            rd_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_result   <= '0;
            wb_flags    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            wb_valid <= take_single | take_done | take_timeout;
            if (take_multi) begin
                op_q <= id_op;
                rd_q <= id_rd;
                a_q  <= id_a;
                b_q  <= id_b;
            end
            if (take_single) begin
                wb_rd     <= id_rd;
                wb_result <= fpu_result;
                wb_flags  <= fpu_flags;
            end else if (take_done) begin
                wb_rd     <= rd_q;
                wb_result <= fpu_result;
                wb_flags  <= fpu_flags;
            end else if (take_timeout) begin
                wb_rd     <= rd_q;
                wb_result <= CANON_NAN;
                wb_flags  <= 5'(1) << FLAG_NV;
            end
            if (take_timeout) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: scenario tasks with randomized
// operands/latencies checked against cycle expectations derived arithmetically.
module tb_fpu_issue_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_op, id_rd;
    logic [31:0] id_a, id_b;
    logic        ex_flush;
    logic        fpu_start;
    logic [4:0]  fpu_op;
    logic [31:0] fpu_a, fpu_b;
    logic        fpu_done;
    logic [31:0] fpu_result;
    logic [4:0]  fpu_flags;
    logic        stall, wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic [4:0]  wb_flags;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;
    bit to_sticky = 1'b0;

    always #5 clk = ~clk;

    fpu_issue_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_op       (id_op),
        .id_rd       (id_rd),
        .id_a        (id_a),
        .id_b        (id_b),
        .ex_flush    (ex_flush),
        .fpu_start   (fpu_start),
        .fpu_op      (fpu_op),
        .fpu_a       (fpu_a),
        .fpu_b       (fpu_b),
        .fpu_done    (fpu_done),
        .fpu_result  (fpu_result),
        .fpu_flags   (fpu_flags),
        .stall       (stall),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_result   (wb_result),
        .wb_flags    (wb_flags),
        .timeout_err (timeout_err)
    );

    function automatic bit ref_multi(input logic [4:0] op);
        return (op == 5'd2) || (op == 5'd3) || (op == 5'd11);
    endfunction

    function automatic logic [4:0] rand_single();
        logic [4:0] o;
        do o = 5'($urandom); while (ref_multi(o));
        return o;
    endfunction

    function automatic logic [4:0] rand_multi();
        logic [4:0] mops [3];
        mops = '{5'd2, 5'd3, 5'd11};
        return mops[$urandom_range(0, 2)];
    endfunction

    task automatic run_idle();
        logic [4:0] op;
        op = rand_single();
        @(negedge clk);
        id_valid = 1'b0; ex_flush = 1'b0; fpu_done = 1'($urandom_range(0, 1));
        id_op = op; id_a = $urandom; id_b = $urandom;
        #1;
        checks++;
        if (stall !== 1'b0 || fpu_start !== 1'b0 || wb_valid !== 1'b0 || fpu_op !== op || fpu_a !== id_a) begin
            errors++;
            $display("FAIL idle: stall=%b start=%b wb_valid=%b op=%h a=%h, required 0/0/0 op=%h a=%h",
                     stall, fpu_start, wb_valid, fpu_op, fpu_a, op, id_a);
        end
        checks++;
        if (timeout_err !== to_sticky) begin
            errors++;
            $display("FAIL idle_timeout_err: got %b required %b", timeout_err, to_sticky);
        end
    endtask

    task automatic run_single(input logic [4:0] op, input logic [4:0] rd, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] res, input logic [4:0] fl);
        @(negedge clk);
        id_valid = 1'b1; id_op = op; id_rd = rd; id_a = a; id_b = b;
        ex_flush = 1'b0; fpu_done = 1'b0; fpu_result = res; fpu_flags = fl;
        #1;
        checks++;
        if (fpu_start !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL single_accept: start=%b stall=%b required 1/0", fpu_start, stall);
        end
        checks++;
        if ({fpu_op, fpu_a, fpu_b} !== {op, a, b}) begin
            errors++;
            $display("FAIL single_operands: %h %h %h required %h %h %h", fpu_op, fpu_a, fpu_b, op, a, b);
        end
        @(negedge clk);
        id_valid = 1'b0; fpu_done = 1'b1; fpu_result = ~res; fpu_flags = ~fl;
        #1;
        checks++;
        if (wb_valid !== 1'b1 || wb_rd !== rd || wb_result !== res || wb_flags !== fl) begin
            errors++;
            $display("FAIL single_wb: valid=%b rd=%0d res=%h fl=%b required 1 rd=%0d res=%h fl=%b",
                     wb_valid, wb_rd, wb_result, wb_flags, rd, res, fl);
        end
        checks++;
        if (fpu_start !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL single_after: start=%b stall=%b required 0/0", fpu_start, stall);
        end
        @(negedge clk);
        fpu_done = 1'b0;
        #1;
        checks++;
        if (wb_valid !== 1'b0 || wb_rd !== rd || wb_result !== res || wb_flags !== fl) begin
            errors++;
            $display("FAIL single_hold: valid=%b rd=%0d res=%h fl=%b required 0 rd=%0d res=%h fl=%b",
                     wb_valid, wb_rd, wb_result, wb_flags, rd, res, fl);
        end
    endtask

    // done_at / flush_at are cycle offsets from acceptance (-1 = never)
    task automatic run_multi(input logic [4:0] op, input logic [4:0] rd, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] res, input logic [4:0] fl,
                             input int done_at, input int flush_at);
        int e;
        bit flushed, timed;
        logic [31:0] exp_res;
        logic [4:0]  exp_fl;
        e = TO;
        if (done_at >= 1 && done_at < e) e = done_at;
        flushed = (flush_at >= 1 && flush_at <= e);
        if (flushed) e = flush_at;
        timed   = !flushed && (done_at != e);
        exp_res = timed ? 32'h7FC0_0000 : res;
        exp_fl  = timed ? 5'b10000 : fl;
        for (int c = 0; c <= e + 1; c++) begin
            @(negedge clk);
            id_valid = 1'b1; id_op = op;
            id_rd = (c == 0) ? rd : 5'($urandom);
            id_a  = (c == 0) ? a : $urandom;
            id_b  = (c == 0) ? b : $urandom;
            ex_flush   = (c == flush_at);
            fpu_done   = (c == done_at);
            fpu_result = (c == done_at) ? res : $urandom;
            fpu_flags  = (c == done_at) ? fl : 5'($urandom);
            #1;
            if (timed && c == e + 1) to_sticky = 1'b1;
            checks++;
            if (stall !== (c <= e) || fpu_start !== (c >= 1 && c <= e)) begin
                errors++;
                $display("FAIL multi_handshake c=%0d: stall=%b start=%b required %b/%b",
                         c, stall, fpu_start, (c <= e), (c >= 1 && c <= e));
            end
            checks++;
            if ({fpu_op, fpu_a, fpu_b} !== {op, a, b}) begin
                errors++;
                $display("FAIL multi_operands c=%0d: %h %h %h required %h %h %h", c, fpu_op, fpu_a, fpu_b, op, a, b);
            end
            checks++;
            if (wb_valid !== (!flushed && c == e + 1)) begin
                errors++;
                $display("FAIL multi_wb_valid c=%0d: got %b required %b", c, wb_valid, (!flushed && c == e + 1));
            end
            if (!flushed && c == e + 1) begin
                checks++;
                if (wb_rd !== rd || wb_result !== exp_res || wb_flags !== exp_fl) begin
                    errors++;
                    $display("FAIL multi_wb_data: rd=%0d res=%h fl=%b required rd=%0d res=%h fl=%b",
                             wb_rd, wb_result, wb_flags, rd, exp_res, exp_fl);
                end
            end
            checks++;
            if (timeout_err !== to_sticky) begin
                errors++;
                $display("FAIL multi_timeout_err c=%0d: got %b required %b", c, timeout_err, to_sticky);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        id_valid = 1'b0; id_op = '0; id_rd = '0; id_a = '0; id_b = '0;
        ex_flush = 1'b0; fpu_done = 1'b0; fpu_result = '0; fpu_flags = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({fpu_start, stall, wb_valid, timeout_err} !== 4'b0 || {fpu_op, fpu_a, fpu_b} !== 69'b0 ||
            {wb_rd, wb_result, wb_flags} !== 42'b0) begin
            errors++;
            $display("FAIL reset_outputs: start=%b stall=%b wbv=%b to=%b op=%h a=%h b=%h rd=%h res=%h fl=%h required all 0",
                     fpu_start, stall, wb_valid, timeout_err, fpu_op, fpu_a, fpu_b, wb_rd, wb_result, wb_flags);
        end
        id_valid = 1'b1; id_op = 5'd3;
        #1;
        checks++;
        if (stall !== 1'b0 || fpu_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_accept: stall=%b start=%b required 0/0", stall, fpu_start);
        end
        @(negedge clk);
        id_valid = 1'b0; id_op = '0;
        reset = 1'b1;
    endtask

    task automatic test_single();
        run_single(5'b00000, 5'd5, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5'b00000);
        for (int i = 0; i < 6; i++)
            run_single(rand_single(), 5'($urandom), $urandom, $urandom, $urandom, 5'($urandom));
        run_idle();
    endtask

    task automatic test_multi();
        run_multi(5'b00011, 5'd7, 32'h4080_0000, 32'h4100_0000, 32'h3F00_0000, 5'b00001, 5, -1);
        run_idle();
        run_multi(5'b00010, 5'd12, $urandom, $urandom, $urandom, 5'($urandom), 1, -1);
        run_idle();
        for (int i = 0; i < 5; i++) begin
            run_multi(rand_multi(), 5'($urandom), $urandom, $urandom, $urandom, 5'($urandom),
                      $urandom_range(1, 6), -1);
            run_idle();
        end
    endtask

    task automatic test_back_to_back();
        run_multi(5'b01011, 5'd9, $urandom, $urandom, $urandom, 5'($urandom), 3, -1);
        run_multi(5'b01011, 5'd20, $urandom, $urandom, $urandom, 5'($urandom), 3, -1);
        run_idle();
    endtask

    task automatic test_flush();
        run_multi(5'b00011, 5'd3, $urandom, $urandom, $urandom, 5'($urandom), 6, 3);
        run_idle();
        run_multi(5'b01011, 5'd4, $urandom, $urandom, $urandom, 5'($urandom), 2, 2);
        run_idle();
        run_multi(5'b00010, 5'd6, $urandom, $urandom, $urandom, 5'($urandom), 2, 3);
        run_idle();
        @(negedge clk);
        id_valid = 1'b1; id_op = rand_single(); ex_flush = 1'b1; fpu_done = 1'b0;
        #1;
        checks++;
        if (fpu_start !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_single: start=%b stall=%b required 0/0", fpu_start, stall);
        end
        @(negedge clk);
        id_op = rand_multi();
        #1;
        checks++;
        if (fpu_start !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_multi: start=%b stall=%b wbv=%b required 0/0/0", fpu_start, stall, wb_valid);
        end
        run_idle();
    endtask

    task automatic test_timeout();
        run_multi(5'b00011, 5'd17, $urandom, $urandom, $urandom, 5'($urandom), -1, -1);
        run_idle();
        run_multi(5'b01011, 5'd18, $urandom, $urandom, $urandom, 5'($urandom), 2, -1);
        run_idle();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        id_valid = 1'b1; id_op = 5'b01011; id_rd = 5'd21; id_a = $urandom; id_b = $urandom;
        ex_flush = 1'b0; fpu_done = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({fpu_start, stall, wb_valid, timeout_err} !== 4'b0 || {fpu_op, fpu_a, fpu_b} !== 69'b0 ||
            {wb_rd, wb_result, wb_flags} !== 42'b0) begin
            errors++;
            $display("FAIL reset_mid_multi: start=%b stall=%b wbv=%b to=%b op=%h a=%h rd=%h res=%h fl=%h required all 0",
                     fpu_start, stall, wb_valid, timeout_err, fpu_op, fpu_a, wb_rd, wb_result, wb_flags);
        end
        to_sticky = 1'b0;
        @(negedge clk);
        id_valid = 1'b0;
        reset = 1'b1;
        run_single(rand_single(), 5'($urandom), $urandom, $urandom, $urandom, 5'($urandom));
        run_idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_back_to_back();
        test_flush();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
